fetch_sequencer: RTL

//  Instruction-fetch end of the ir interface: owns PC, program-ROM address and the IR register that

---
 rtl/nic8_pkg.sv | 25 ++
 rtl/fetch_sequencer_if.sv | 32 +++
 rtl/step_handshake.sv | 58 +++++
 rtl/fetch_sequencer.sv | 66 ++++++
 4 files changed

// File: rtl/nic8_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nic8_pkg : shared constants, fetch FSM states and IR field layout          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package nic8_pkg;

  localparam logic [7:0] c_nop_ir = 8'h00;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2,
    ACK    = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic       b7;
    logic [2:0] dest;
    logic       b3;
    logic [2:0] source;
  } ir_fields_t;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_sequencer_if : ROM/bus/decode feedback and front-panel handshake     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface fetch_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       romData;
  logic [7:0]       dbus;
  logic             denyFetch;
  logic             doJumpBar;
  logic             run;
  logic             stepReq;
  logic [7:0]       pc;
  logic [7:0]       ir;
  logic             exec;
  logic             bubble;
  logic             stepAck;
  logic [CNT_W-1:0] insnCount;

  modport master (
    input  romData, dbus, denyFetch, doJumpBar, run, stepReq,
    output pc, ir, exec, bubble, stepAck, insnCount
  );

  modport slave (
    output romData, dbus, denyFetch, doJumpBar, run, stepReq,
    input  pc, ir, exec, bubble, stepAck, insnCount
  );
endinterface
`default_nettype wire

// File: rtl/step_handshake.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | step_handshake : run/halt/single-step FSM producing exec and stepAck       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module step_handshake
  import nic8_pkg::*;
(
  input  logic clk,
  input  logic resetBar,
  input  logic run,
  input  logic stepReq,
  output logic exec,
  output logic stepAck
);

  fetch_state_e r_state;
  fetch_state_e w_next;
  logic         r_ack;

  always_ff @(posedge clk) begin
    if (!resetBar) begin
      r_state <= run ? RUN : HALTED;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack   <= (w_next == ACK);
    end
  end

  // exec depends on state alone so the datapath never sees a combinational path from inputs
  always_comb begin
    w_next = r_state;
    exec   = 1'b0;
    case (r_state)
      RUN: begin
        exec = 1'b1;
        if (!run) w_next = HALTED;
      end
      HALTED: begin
        if (run)                    w_next = RUN;
        else if (stepReq && !r_ack) w_next = STEP;
      end
      STEP: begin
        exec   = 1'b1;
        w_next = ACK;
      end
      ACK: begin
        if (!stepReq) w_next = run ? RUN : HALTED;
      end
      default: w_next = HALTED;
    endcase
  end

  assign stepAck = r_ack;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_sequencer : PC / IR / retired-count datapath with bubble insertion   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_sequencer
  import nic8_pkg::*;
#(
  parameter logic [7:0] NOP_IR = c_nop_ir,
  parameter int         CNT_W  = 16
) (
  input  logic               clk,
  input  logic               resetBar,
  fetch_sequencer_if.master  bus
);

  logic [7:0]       r_pc;
  logic [7:0]       r_ir;
  logic             r_bubble;
  logic [CNT_W-1:0] r_cnt;
  logic             w_exec;
  logic             w_step_ack;

  step_handshake u_step (
    .clk      (clk),
    .resetBar (resetBar),
    .run      (bus.run),
    .stepReq  (bus.stepReq),
    .exec     (w_exec),
    .stepAck  (w_step_ack)
  );

  // The count reflects the instruction leaving ir, so a bubble retiring never bumps it
  always_ff @(posedge clk) begin
    if (!resetBar) begin
      r_pc     <= 8'h00;
      r_ir     <= NOP_IR;
      r_bubble <= 1'b1;
      r_cnt    <= '0;
    end else if (w_exec) begin
      if (!r_bubble) r_cnt <= r_cnt + CNT_W'(1);
      if (!bus.doJumpBar) begin
        r_pc     <= bus.dbus;
        r_ir     <= NOP_IR;
        r_bubble <= 1'b1;
      end else if (bus.denyFetch) begin
        r_pc     <= r_pc + 8'd1;
        r_ir     <= NOP_IR;
        r_bubble <= 1'b1;
      end else begin
        r_pc     <= r_pc + 8'd1;
        r_ir     <= bus.romData;
        r_bubble <= 1'b0;
      end
    end
  end

  assign bus.pc        = r_pc;
  assign bus.ir        = r_ir;
  assign bus.bubble    = r_bubble;
  assign bus.exec      = w_exec;
  assign bus.stepAck   = w_step_ack;
  assign bus.insnCount = r_cnt;

endmodule
`default_nettype wire
